// File: rtl/maxpool_engine.sv
// maxpool_engine: reduces K*K-pixel FP16 windows from a data FIFO to their maxima.
module maxpool_engine #(
    parameter int DATA_W = 16,
    parameter int KSZ_W  = 4,
    parameter int WCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              maxpool_ready,
    input  logic [KSZ_W-1:0]  kernel_size,
    input  logic [WCNT_W-1:0] window_count,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              maxpool_valid,
    output logic              busy
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_EMIT, S_DONE} state_t;
    state_t                 r_state;
    logic [2*KSZ_W-1:0]     r_ksq, r_elem;
    logic [WCNT_W-1:0]      r_wcnt, r_win;
    logic [DATA_W-1:0]      r_max;
    logic [2*KSZ_W-1:0]     w_k_ext, w_elem_nx;
    logic [WCNT_W-1:0]      w_win_nx;
    logic [DATA_W-1:0]      w_pix_max;
    // Sign-magnitude compare; b replaces a only when strictly larger, so ties keep a.
    function automatic logic [DATA_W-1:0] fp_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (a[DATA_W-1] != b[DATA_W-1]) return a[DATA_W-1] ? b : a;
        if (!a[DATA_W-1]) return (b[DATA_W-2:0] > a[DATA_W-2:0]) ? b : a;
        return (b[DATA_W-2:0] < a[DATA_W-2:0]) ? b : a;
    endfunction
    assign w_k_ext    = {{KSZ_W{1'b0}}, kernel_size};
    assign w_elem_nx  = r_elem + 1'b1;
    assign w_win_nx   = r_win + 1'b1;
    assign w_pix_max  = (r_elem == '0) ? fifo_dout : fp_max(r_max, fifo_dout);
    assign fifo_rd_en = (r_state == S_ACCUM) && !fifo_empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ksq         <= '0;
            r_elem        <= '0;
            r_wcnt        <= '0;
            r_win         <= '0;
            r_max         <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            maxpool_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (maxpool_ready) begin
                    r_state <= S_LOAD;
                    busy    <= 1'b1;
                end
                S_LOAD: begin
                    r_ksq  <= w_k_ext * w_k_ext;
                    r_wcnt <= window_count;
                    r_elem <= '0;
                    r_win  <= '0;
                    if (kernel_size == '0 || window_count == '0) begin
                        r_state       <= S_DONE;
                        maxpool_valid <= 1'b1;
                    end else r_state <= S_ACCUM;
                end
                S_ACCUM: if (!fifo_empty) begin
                    r_max <= w_pix_max;
                    if (w_elem_nx == r_ksq) begin
                        r_elem    <= '0;
                        r_state   <= S_EMIT;
                        out_data  <= w_pix_max;
                        out_valid <= 1'b1;
                    end else r_elem <= w_elem_nx;
                end
                S_EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_win     <= w_win_nx;
                    if (w_win_nx == r_wcnt) begin
                        r_state       <= S_DONE;
                        maxpool_valid <= 1'b1;
                    end else r_state <= S_ACCUM;
                end
                S_DONE: if (!maxpool_ready) begin
                    r_state       <= S_IDLE;
                    maxpool_valid <= 1'b0;
                    busy          <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
